// File: rtl/aes_loader_pkg.sv
// Shared widths, block type and packer FSM encoding for the AES input loader.
package aes_loader_pkg;
  localparam int WORD_W        = 32;
  localparam int BLOCK_W       = 128;
  localparam int WORDS_PER_BLK = 4;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic {
    PK_IDLE = 1'b0,
    PK_FILL = 1'b1
  } pk_state_e;
endpackage

// File: rtl/aes_word_packer.sv
// Packs 32-bit words MSW-first into a 128-bit block and checks in_last framing.
module aes_word_packer
  import aes_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output block_t            block,
  output logic              push,
  output logic              frame_err
);
  pk_state_e                st_q, st_d;
  logic [1:0]               widx_q, widx_d;
  logic [BLOCK_W-1:WORD_W]  asm_q;
  logic                     err_d;
  logic                     accept;
  logic                     last_lane;

  assign accept    = in_valid && in_ready;
  assign last_lane = (st_q == PK_FILL) && (widx_q == 2'd3);
  // The final word bypasses the assembly register so the block is pushed on its accept edge.
  assign block     = {asm_q, in_data};

  always_comb begin
    st_d   = st_q;
    widx_d = widx_q;
    push   = 1'b0;
    err_d  = 1'b0;
    if (accept) begin
      if (!last_lane) begin
        if (in_last) begin
          err_d  = 1'b1;
          st_d   = PK_IDLE;
          widx_d = 2'd0;
        end else begin
          st_d   = PK_FILL;
          widx_d = widx_q + 2'd1;
        end
      end else begin
        st_d   = PK_IDLE;
        widx_d = 2'd0;
        if (in_last) push  = 1'b1;
        else         err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= PK_IDLE;
      widx_q    <= 2'd0;
      frame_err <= 1'b0;
    end else begin
      st_q      <= st_d;
      widx_q    <= widx_d;
      frame_err <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      case (widx_q)
        2'd0:    asm_q[127:96] <= in_data;
        2'd1:    asm_q[95:64]  <= in_data;
        2'd2:    asm_q[63:32]  <= in_data;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/aes_state_loader.sv
// AES input stage: word packer feeding a DEPTH-entry block FIFO with a registered state output.
module aes_state_loader
  import aes_loader_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output block_t            state,
  output logic              state_valid,
  input  logic              state_ready,
  output logic              frame_err,
  output logic [15:0]       blk_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  block_t          mem [DEPTH];
  block_t          pk_block;
  block_t          state_q;
  logic [PW-1:0]   wptr, rptr, rptr_n;
  logic [OW-1:0]   occ, occ_n;
  logic [15:0]     cnt_q;
  logic            push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready    = (occ < OW'(DEPTH));
  assign state_valid = (occ != '0);
  assign pop         = state_valid && state_ready;
  assign state       = state_q;
  assign blk_count   = cnt_q;

  aes_word_packer u_pk (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .block     (pk_block),
    .push      (push),
    .frame_err (frame_err)
  );

  always_comb begin
    rptr_n = pop ? nxt(rptr) : rptr;
    case ({push, pop})
      2'b10:   occ_n = occ + OW'(1);
      2'b01:   occ_n = occ - OW'(1);
      default: occ_n = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= pk_block;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      occ     <= '0;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      rptr <= rptr_n;
      occ  <= occ_n;
      if (pop) cnt_q <= cnt_q + 16'd1;
      // If the new head is the slot being written this edge, take the incoming block directly.
      if (occ_n != '0)
        state_q <= (push && (rptr_n == wptr)) ? pk_block : mem[rptr_n];
    end
  end
endmodule
